// File: rtl/game_logic_timed_multi_if.sv
// Handshake-free control/display bundle between score generators, game controller and display mux.
// pause exists only when GAME_PAUSE_EN is defined.
interface game_logic_timed_multi_if #(
  parameter int NUM_CH  = 4,
  parameter int SCORE_W = 5,
  parameter int TOTAL_W = 8,
  parameter int TIMER_W = 6
);
  logic                        enable;
  logic                        clear;
  logic [NUM_CH*SCORE_W-1:0]   score_bus;
  logic                        reward_addtime;
  logic                        reward_test;
`ifdef GAME_PAUSE_EN
  logic                        pause;
`endif
  logic [15:0]                 seg_out;
  logic [15:0]                 led_out;
  logic [TIMER_W-1:0]          timer;
  logic                        gameover;
  logic [TOTAL_W-1:0]          final_score;
  logic [1:0]                  state;

  modport master (
`ifdef GAME_PAUSE_EN
    output pause,
`endif
    output enable, clear, score_bus, reward_addtime, reward_test,
    input  seg_out, led_out, timer, gameover, final_score, state
  );

  modport slave (
`ifdef GAME_PAUSE_EN
    input  pause,
`endif
    input  enable, clear, score_bus, reward_addtime, reward_test,
    output seg_out, led_out, timer, gameover, final_score, state
  );
endinterface

// File: rtl/game_logic_timed_multi.sv
// Countdown-survival controller: summed score (1 cycle), 1 s countdown with milestone/reward bonuses, no backpressure.
// Optional GAME_PAUSE_EN adds a pause input that freezes the countdown and defers bonus credit.
module game_logic_timed_multi #(
  parameter int NUM_CH     = 4,
  parameter int SCORE_W    = 5,
  parameter int TOTAL_W    = 8,
  parameter int TIMER_W    = 6,
  parameter int TIMER_INIT = 16,
  parameter int TIMER_MAX  = 63,
  parameter int TICK_DIV   = 100000000,
  parameter int BONUS_STEP = 5
) (
  input  logic clk,
  input  logic rst,
  game_logic_timed_multi_if.slave bus
);
  localparam int TW2   = TIMER_W + 2;
  localparam int MS_W  = TOTAL_W + 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] T_INIT   = TIMER_W'(TIMER_INIT);
  localparam logic [TIMER_W-1:0] T_MAX    = TIMER_W'(TIMER_MAX);
  localparam logic [MS_W-1:0]    MS_STEP  = MS_W'(BONUS_STEP);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [CNT_W-1:0]   r_cnt;
  logic [TOTAL_W-1:0] r_total;
  logic [MS_W-1:0]    r_next_ms;
  logic               r_gameover;
  logic [TOTAL_W-1:0] r_final;
  logic [15:0]        r_seg;
  logic [15:0]        r_led;
  logic               r_rew_prev;

  logic [TOTAL_W-1:0] w_sum;
  logic               w_rew;
  logic               w_rw;
  logic               w_bonus;
  logic               w_tick;
  logic               w_pause;
  logic [TIMER_W-1:0] w_pend;
  logic [TW2-1:0]     w_tnext_raw;
  logic [TIMER_W-1:0] w_tnext;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_sum = w_sum + TOTAL_W'(bus.score_bus[i*SCORE_W +: SCORE_W]);
  end

  assign w_rew   = bus.reward_addtime | bus.reward_test;
  assign w_rw    = w_rew & ~r_rew_prev;
  // next_ms only advances past the score once, so a dip and re-rise never re-grants
  assign w_bonus = (r_state == S_RUN) && ({1'b0, r_total} >= r_next_ms);
  assign w_tick  = (r_cnt == CNT_LAST);

  assign w_tnext_raw = TW2'(r_timer) + TW2'(w_bonus) + TW2'(w_rw) + TW2'(w_pend) - TW2'(w_tick);

  always_comb begin
    if (w_tnext_raw[TW2-1])
      w_tnext = '0;
    else if (w_tnext_raw > TW2'(TIMER_MAX))
      w_tnext = T_MAX;
    else
      w_tnext = w_tnext_raw[TIMER_W-1:0];
  end

`ifdef GAME_PAUSE_EN
  logic [TIMER_W-1:0] r_pend;
  logic [TW2-1:0]     w_pend_sum;

  assign w_pause    = bus.pause;
  assign w_pend     = r_pend;
  assign w_pend_sum = TW2'(r_pend) + TW2'(w_bonus) + TW2'(w_rw);

  // credit earned while paused is banked here and consumed on the first unpaused cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pend <= '0;
    else if (r_state == S_RUN && bus.enable && w_pause)
      r_pend <= (w_pend_sum > TW2'(TIMER_MAX)) ? T_MAX : w_pend_sum[TIMER_W-1:0];
    else
      r_pend <= '0;
  end
`else
  assign w_pause = 1'b0;
  assign w_pend  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= T_INIT;
      r_cnt      <= '0;
      r_total    <= '0;
      r_next_ms  <= MS_STEP;
      r_gameover <= 1'b0;
      r_final    <= '0;
      r_seg      <= '0;
      r_led      <= '0;
      r_rew_prev <= 1'b0;
    end else begin
      r_rew_prev <= w_rew;
      r_led      <= 16'(r_timer);
      if (r_state == S_IDLE && bus.clear) begin
        r_total <= '0;
        r_seg   <= '0;
      end else begin
        r_total <= w_sum;
        r_seg   <= 16'(r_total);
      end

      case (r_state)
        S_IDLE: begin
          r_timer    <= T_INIT;
          r_cnt      <= '0;
          r_next_ms  <= MS_STEP;
          r_gameover <= 1'b0;
          if (bus.clear)
            r_final <= '0;
          if (bus.enable)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
            r_timer <= T_INIT;
            r_cnt   <= '0;
          end else begin
            if (w_bonus)
              r_next_ms <= r_next_ms + MS_STEP;
            if (!w_pause) begin
              r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
              if (w_tnext == '0) begin
                r_state    <= S_OVER;
                r_timer    <= '0;
                r_final    <= r_total;
                r_gameover <= 1'b1;
              end else begin
                r_timer <= w_tnext;
              end
            end
          end
        end
        S_OVER: begin
          if (!bus.enable) begin
            r_state    <= S_IDLE;
            r_gameover <= 1'b0;
            r_timer    <= T_INIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.seg_out     = r_seg;
  assign bus.led_out     = r_led;
  assign bus.timer       = r_timer;
  assign bus.gameover    = r_gameover;
  assign bus.final_score = r_final;
  assign bus.state       = r_state;
endmodule
